// File: rtl/player_plotter_pkg.sv
// Shared types and constants for the player sprite plotter.
package player_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAW,
        S_WAIT,
        S_ERASE,
        S_UPDATE,
        S_DONE
    } state_t;

    localparam logic [2:0]  BG_COLOUR     = 3'b000;
    localparam int unsigned SCREEN_WIDTH  = 160;
    localparam int unsigned SCREEN_HEIGHT = 120;
    localparam int unsigned SPRITE_PIXELS = 16;

endpackage

// File: rtl/player_plotter_sweep.sv
// Row-major pixel walker over the sprite rectangle; shared by draw and erase passes.
module sprite_sweep #(
    parameter int unsigned X_W      = 8,
    parameter int unsigned Y_W      = 7,
    parameter int unsigned SPRITE_W = 4,
    parameter int unsigned SPRITE_H = 4
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic [X_W-1:0] base_x,
    input  logic [Y_W-1:0] base_y,
    output logic [X_W-1:0] dx,
    output logic [Y_W-1:0] dy,
    output logic [X_W-1:0] px,
    output logic [Y_W-1:0] py,
    output logic           busy,
    output logic           done
);
    localparam int unsigned PIXELS = SPRITE_W * SPRITE_H;
    localparam int unsigned CW     = (PIXELS > 1) ? $clog2(PIXELS) : 1;

    logic [CW-1:0] idx;

    // start is held for the whole pass; dropping it rewinds the walker
    always_ff @(posedge clock) begin
        if (reset || !start || done) begin
            idx <= '0;
        end else begin
            idx <= idx + CW'(1);
        end
    end

    always_comb begin
        dx   = X_W'(32'(idx) % SPRITE_W);
        dy   = Y_W'(32'(idx) / SPRITE_W);
        px   = base_x + dx;
        py   = base_y + dy;
        busy = start;
        done = start && (idx == CW'(PIXELS - 1));
    end

endmodule

// File: rtl/player_plotter.sv
// Player sprite datapath: holds position/colour and animates draw/erase/move steps.
module player_plotter
    import player_pkg::*;
#(
    parameter int unsigned X_W       = 8,
    parameter int unsigned Y_W       = 7,
    parameter int unsigned SPRITE_W  = 4,
    parameter int unsigned SPRITE_H  = 4,
    parameter int unsigned SCREEN_H  = SCREEN_HEIGHT,
    parameter int unsigned END_X     = 156,
    parameter int unsigned OBS_W     = 8,
    parameter int unsigned OBS_H     = 8,
    parameter int unsigned FRAME_DIV = 833334
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           ld_x,
    input  logic           ld_y,
    input  logic           ld_colour,
    input  logic           writeEnable,
    input  logic           draw,
    input  logic [X_W-1:0] x_in,
    input  logic [Y_W-1:0] y_in,
    input  logic [2:0]     colour_in,
    input  logic           move_up,
    input  logic           move_down,
    input  logic [X_W-1:0] obs_x,
    input  logic [Y_W-1:0] obs_y,
    output logic [X_W-1:0] x_out,
    output logic [Y_W-1:0] y_out,
    output logic [2:0]     colour_out,
    output logic           plot,
    output logic           finish
);
    localparam int unsigned FW    = $clog2(FRAME_DIV + 1);
    localparam logic [Y_W:0] Y_MAX = (Y_W+1)'(SCREEN_H - SPRITE_H);

    state_t         state;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [2:0]     colour;
    logic [FW-1:0]  frame_cnt;

    logic           sweep_start;
    logic           sweep_busy;
    logic           sweep_done;
    logic [X_W-1:0] dx;
    logic [X_W-1:0] px;
    logic [Y_W-1:0] dy;
    logic [Y_W-1:0] py;

    logic [X_W:0]   x_next;
    logic [Y_W:0]   y_inc;
    logic [Y_W:0]   y_next;
    logic           hit_end;
    logic           hit_obs;

    assign sweep_start = draw && ((state == S_DRAW) || (state == S_ERASE));

    sprite_sweep #(
        .X_W      (X_W),
        .Y_W      (Y_W),
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H)
    ) u_sweep (
        .clock  (clock),
        .reset  (reset),
        .start  (sweep_start),
        .base_x (x),
        .base_y (y),
        .dx     (dx),
        .dy     (dy),
        .px     (px),
        .py     (py),
        .busy   (sweep_busy),
        .done   (sweep_done)
    );

    // Next position and finish tests, one bit wider than the coordinates so nothing wraps
    always_comb begin
        x_next = {1'b0, x} + (X_W+1)'(1);
        y_inc  = {1'b0, y} + (Y_W+1)'(1);
        y_next = {1'b0, y};
        if (move_up && !move_down) begin
            y_next = (y == '0) ? '0 : ({1'b0, y} - (Y_W+1)'(1));
        end else if (move_down && !move_up) begin
            y_next = (y_inc > Y_MAX) ? Y_MAX : y_inc;
        end
        hit_end = (x_next + (X_W+1)'(SPRITE_W)) >= (X_W+1)'(END_X);
        hit_obs = (x_next < ({1'b0, obs_x} + (X_W+1)'(OBS_W)))
               && ({1'b0, obs_x} < (x_next + (X_W+1)'(SPRITE_W)))
               && (y_next < ({1'b0, obs_y} + (Y_W+1)'(OBS_H)))
               && ({1'b0, obs_y} < (y_next + (Y_W+1)'(SPRITE_H)));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            x          <= '0;
            y          <= '0;
            colour     <= '0;
            frame_cnt  <= '0;
            x_out      <= '0;
            y_out      <= '0;
            colour_out <= '0;
            plot       <= 1'b0;
            finish     <= 1'b0;
        end else begin
            plot <= 1'b0;
            if (!draw) begin
                if (ld_x)      x      <= x_in;
                if (ld_y)      y      <= y_in;
                if (ld_colour) colour <= colour_in;
                if ((state == S_IDLE) && (ld_x || ld_y || ld_colour)) finish <= 1'b0;
            end

            if (!draw && (state != S_DONE)) begin
                state     <= S_IDLE;
                frame_cnt <= '0;
            end else begin
                case (state)
                    S_IDLE: state <= S_DRAW;
                    S_DRAW, S_ERASE: begin
                        x_out      <= px;
                        y_out      <= py;
                        colour_out <= (state == S_DRAW) ? colour : BG_COLOUR;
                        plot       <= writeEnable && sweep_busy;
                        if (sweep_done) state <= (state == S_DRAW) ? S_WAIT : S_UPDATE;
                    end
                    S_WAIT: begin
                        if (frame_cnt == FW'(FRAME_DIV - 1)) begin
                            frame_cnt <= '0;
                            state     <= S_ERASE;
                        end else begin
                            frame_cnt <= frame_cnt + FW'(1);
                        end
                    end
                    S_UPDATE: begin
                        x <= x_next[X_W-1:0];
                        y <= y_next[Y_W-1:0];
                        if (hit_end || hit_obs) begin
                            finish <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            state  <= S_DRAW;
                        end
                    end
                    S_DONE:  state <= S_DONE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    sweep_tracks_base: assert property (@(posedge clock) disable iff (reset)
        sweep_busy |-> ((px == x + dx) && (py == y + dy)));

endmodule

// File: tb/tb_player_plotter.sv
// Self-checking bench: table vectors, random steps against a position model, abort sequences.
module tb_player_plotter;
    localparam int FD = 4;

    logic       clock = 1'b0;
    logic       reset, ld_x, ld_y, ld_colour, writeEnable, draw;
    logic [7:0] x_in, obs_x, x_out;
    logic [6:0] y_in, obs_y, y_out;
    logic [2:0] colour_in, colour_out;
    logic       move_up, move_down, plot, finish;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0] x0;
        logic [6:0] y0;
        logic [2:0] c0;
        logic       up;
        logic       dn;
        logic [7:0] ox;
        logic [6:0] oy;
        logic [6:0] y1;
        logic       fin;
    } vec_t;

    vec_t vecs [12];

    player_plotter #(.FRAME_DIV(FD)) dut (
        .clock       (clock),
        .reset       (reset),
        .ld_x        (ld_x),
        .ld_y        (ld_y),
        .ld_colour   (ld_colour),
        .writeEnable (writeEnable),
        .draw        (draw),
        .x_in        (x_in),
        .y_in        (y_in),
        .colour_in   (colour_in),
        .move_up     (move_up),
        .move_down   (move_down),
        .obs_x       (obs_x),
        .obs_y       (obs_y),
        .x_out       (x_out),
        .y_out       (y_out),
        .colour_out  (colour_out),
        .plot        (plot),
        .finish      (finish)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Step rules straight from the game description: one column right, clamped steering, end/overlap test
    function automatic void model(input int x0, input int y0, input bit up, input bit dn,
                                  input int ox, input int oy, output int y1, output bit fin);
        int x1;
        x1 = x0 + 1;
        y1 = y0;
        if (up && !dn)      y1 = (y0 > 0) ? y0 - 1 : 0;
        else if (dn && !up) y1 = (y0 + 1 > 116) ? 116 : y0 + 1;
        fin = (x1 + 4 >= 156) ||
              ((x1 < ox + 8) && (ox < x1 + 4) && (y1 < oy + 8) && (oy < y1 + 4));
    endfunction

    task automatic idle_inputs();
        ld_x = 0; ld_y = 0; ld_colour = 0; draw = 0; writeEnable = 0;
    endtask

    task automatic load(input int x0, input int y0, input int c0);
        @(negedge clock);
        reset = 1; idle_inputs();
        @(negedge clock);
        reset = 0;
        ld_x = 1; ld_y = 1; ld_colour = 1;
        x_in = 8'(x0); y_in = 7'(y0); colour_in = 3'(c0);
        @(negedge clock);
        ld_x = 0; ld_y = 0; ld_colour = 0;
        draw = 1; writeEnable = 1;
    endtask

    // Sample t is taken at the negedge after the t-th rising edge that sees draw high
    task automatic scenario(input string name, input vec_t v);
        int k, ex, ey, ec;
        bit ep;
        obs_x = v.ox; obs_y = v.oy; move_up = v.up; move_down = v.dn;
        load(int'(v.x0), int'(v.y0), int'(v.c0));
        for (int t = 1; t <= 53 + FD; t++) begin
            @(negedge clock);
            ep = 0; ex = 0; ey = 0; ec = 0;
            if (t >= 2 && t <= 17) begin
                ep = 1; k = t - 2;
                ex = int'(v.x0) + k % 4; ey = int'(v.y0) + k / 4; ec = int'(v.c0);
            end else if (t >= 18 + FD && t <= 33 + FD) begin
                ep = 1; k = t - 18 - FD;
                ex = int'(v.x0) + k % 4; ey = int'(v.y0) + k / 4; ec = 0;
            end else if (!v.fin && t >= 35 + FD && t <= 50 + FD) begin
                ep = 1; k = t - 35 - FD;
                ex = int'(v.x0) + 1 + k % 4; ey = int'(v.y1) + k / 4; ec = int'(v.c0);
            end
            check({name, " plot"}, int'(plot), int'(ep));
            if (ep && plot) begin
                check({name, " x_out"}, int'(x_out), ex);
                check({name, " y_out"}, int'(y_out), ey);
                check({name, " colour_out"}, int'(colour_out), ec);
            end
            if (t == 33 + FD) check({name, " finish before update"}, int'(finish), 0);
            if (t == 34 + FD) check({name, " finish after update"}, int'(finish), int'(v.fin));
        end
        draw = 0;
    endtask

    initial begin
        vec_t v;
        int   y1;
        bit   fin;
        int   plots;

        vecs[0]  = '{8'd10,  7'd50,  3'd4, 1'b0, 1'b0, 8'd100, 7'd0,   7'd50,  1'b0};
        vecs[1]  = '{8'd10,  7'd0,   3'd5, 1'b1, 1'b0, 8'd100, 7'd0,   7'd0,   1'b0};
        vecs[2]  = '{8'd10,  7'd116, 3'd6, 1'b0, 1'b1, 8'd100, 7'd0,   7'd116, 1'b0};
        vecs[3]  = '{8'd10,  7'd60,  3'd7, 1'b1, 1'b1, 8'd100, 7'd0,   7'd60,  1'b0};
        vecs[4]  = '{8'd151, 7'd30,  3'd2, 1'b0, 1'b0, 8'd0,   7'd100, 7'd30,  1'b1};
        vecs[5]  = '{8'd150, 7'd30,  3'd2, 1'b0, 1'b0, 8'd0,   7'd100, 7'd30,  1'b0};
        vecs[6]  = '{8'd16,  7'd50,  3'd3, 1'b0, 1'b0, 8'd20,  7'd50,  7'd50,  1'b1};
        vecs[7]  = '{8'd16,  7'd42,  3'd3, 1'b0, 1'b0, 8'd20,  7'd50,  7'd42,  1'b0};
        vecs[8]  = '{8'd20,  7'd60,  3'd1, 1'b1, 1'b0, 8'd20,  7'd50,  7'd59,  1'b0};
        vecs[9]  = '{8'd20,  7'd54,  3'd1, 1'b1, 1'b0, 8'd20,  7'd50,  7'd53,  1'b1};
        vecs[10] = '{8'd15,  7'd50,  3'd1, 1'b0, 1'b0, 8'd20,  7'd50,  7'd50,  1'b0};
        vecs[11] = '{8'd5,   7'd115, 3'd2, 1'b0, 1'b1, 8'd100, 7'd0,   7'd116, 1'b0};

        reset = 1; idle_inputs();
        x_in = 8'd77; y_in = 7'd33; colour_in = 3'd7;
        move_up = 0; move_down = 0; obs_x = 8'd200; obs_y = 7'd0;
        repeat (2) @(negedge clock);
        check("reset plot", int'(plot), 0);
        check("reset x_out", int'(x_out), 0);
        check("reset y_out", int'(y_out), 0);
        check("reset colour_out", int'(colour_out), 0);
        check("reset finish", int'(finish), 0);

        for (int i = 0; i < 12; i++) scenario($sformatf("vec%0d", i), vecs[i]);

        // DONE holds finish, ignores draw and never plots again
        scenario("done_hold", vecs[4]);
        repeat (3) @(negedge clock);
        check("done finish held", int'(finish), 1);
        draw = 1;
        plots = 0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clock);
            if (plot) plots++;
        end
        check("done plot count", plots, 0);
        check("done finish still", int'(finish), 1);
        draw = 0;

        // Reset while the fifth pixel of a draw pass is on the outputs
        obs_x = 8'd200; obs_y = 7'd0; move_up = 0; move_down = 0;
        load(40, 20, 5);
        repeat (6) @(negedge clock);
        check("mid draw plot", int'(plot), 1);
        check("mid draw x_out", int'(x_out), 40);
        check("mid draw y_out", int'(y_out), 21);
        reset = 1; draw = 0;
        @(negedge clock);
        check("abort plot", int'(plot), 0);
        check("abort x_out", int'(x_out), 0);
        check("abort y_out", int'(y_out), 0);
        check("abort colour_out", int'(colour_out), 0);
        check("abort finish", int'(finish), 0);
        reset = 0; draw = 1; writeEnable = 1;
        repeat (2) @(negedge clock);
        check("post reset plot", int'(plot), 1);
        check("post reset x_out", int'(x_out), 0);
        check("post reset y_out", int'(y_out), 0);
        draw = 0;

        // Loads are ignored while drawing; dropping draw in WAIT keeps the position
        load(30, 40, 6);
        for (int t = 1; t <= 19; t++) begin
            @(negedge clock);
            ld_x = (t == 5); ld_y = (t == 5);
            x_in = 8'd99; y_in = 7'd99;
            if (t == 10) begin
                check("ld ignored x_out", int'(x_out), 30);
                check("ld ignored y_out", int'(y_out), 42);
            end
        end
        ld_x = 0; ld_y = 0;
        draw = 0;
        repeat (3) begin
            @(negedge clock);
            check("dropped plot", int'(plot), 0);
        end
        check("dropped finish", int'(finish), 0);
        draw = 1;
        @(negedge clock);
        check("redraw lead plot", int'(plot), 0);
        @(negedge clock);
        check("redraw plot", int'(plot), 1);
        check("redraw x_out", int'(x_out), 30);
        check("redraw y_out", int'(y_out), 40);
        check("redraw colour_out", int'(colour_out), 6);
        draw = 0;

        for (int i = 0; i < 25; i++) begin
            v.x0 = 8'($urandom_range(0, 151));
            v.y0 = 7'($urandom_range(0, 116));
            v.c0 = 3'($urandom_range(0, 7));
            v.up = 1'($urandom_range(0, 1));
            v.dn = 1'($urandom_range(0, 1));
            v.ox = 8'($urandom_range(0, 159));
            v.oy = 7'($urandom_range(0, 119));
            model(int'(v.x0), int'(v.y0), v.up, v.dn, int'(v.ox), int'(v.oy), y1, fin);
            v.y1  = 7'(y1);
            v.fin = fin;
            scenario($sformatf("rand%0d", i), v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/player_plotter.md
# player_plotter

Datapath responder to the game control FSM: consumes `ld_x`/`ld_y`/`ld_colour`/`writeEnable`/`draw`, holds the player sprite's position and colour, and animates it across the 160x120 VGA frame. Each step erases the sprite, moves it, and redraws it. It streams pixel writes (`x_out`, `y_out`, `colour_out`, `plot`) to the VGA adapter. It raises `finish` back to the control FSM when the sprite reaches the end column or overlaps the obstacle.

## Interface
- `X_W`, 8: x coordinate width.
- `Y_W`, 7: y coordinate width.
- `SPRITE_W`, 4: sprite width in pixels.
- `SPRITE_H`, 4: sprite height in pixels.
- `SCREEN_H`, 120: screen height in rows.
- `END_X`, 156: column the sprite's right edge must reach to finish.
- `OBS_W`, 8: obstacle width.
- `OBS_H`, 8: obstacle height.
- `FRAME_DIV`, 833334: WAIT cycles between steps (60 Hz at 50 MHz).
- `clock` in 1: the block's only clock.
- `reset` in 1: synchronous, active-high.
- `ld_x`, `ld_y`, `ld_colour` in 1 each: load enables from control.
- `writeEnable` in 1: gates `plot`.
- `draw` in 1: run animation.
- `x_in` in X_W, `y_in` in Y_W, `colour_in` in 3: start position and colour.
- `move_up`, `move_down` in 1 each: vertical steering (key inputs, already synchronised).
- `obs_x` in X_W, `obs_y` in Y_W: obstacle top-left corner.
- `x_out` out X_W, `y_out` out Y_W, `colour_out` out 3: pixel write address and data.
- `plot` out 1: pixel write strobe.
- `finish` out 1: end reached or collision; sticky.

## Operation
- **Loading.** `ld_x & ~draw` loads `x_in`; likewise `ld_y`→`y_in` and `ld_colour`→`colour_in`. While `draw=1`, the `ld_*` inputs are ignored. A load in IDLE also clears `finish`.
- **States:** IDLE, DRAW, WAIT, ERASE, UPDATE, DONE.
  - IDLE: if `draw`, go to DRAW.
  - DRAW: 16-pixel sweep in the register colour, then WAIT.
  - WAIT: count `FRAME_DIV` cycles, then ERASE.
  - ERASE: 16-pixel sweep in background colour 3'b000, then UPDATE.
  - UPDATE: 1 cycle. Computes the new position and checks finish. Goes to DONE on finish, else DRAW.
  - DONE: `finish=1`, no plotting; holds until `reset`.
- **Sweep.** Row-major order: pixel k → (`x+k%SPRITE_W`, `y+k/SPRITE_W`), k = 0..15.
- **Plot.** `plot = writeEnable & (state is DRAW or ERASE)`.
- **Move (UPDATE).**
  - x increments by 1.
  - `move_up` alone: y−1, clamped at 0.
  - `move_down` alone: y+1, clamped at `SCREEN_H−SPRITE_H`.
  - Both or neither: y unchanged.
- **Finish check** uses the new position.
  - End: `x_new+SPRITE_W ≥ END_X`.
  - Collision: strict rectangle overlap, `x_new < obs_x+OBS_W` and `obs_x < x_new+SPRITE_W`, plus the same test on y.
  - All compares are done at X_W+1 / Y_W+1 bits so there is no wrap.
- **draw deasserted** in any state other than DONE: next state is IDLE and `plot=0`. Position and `finish` are retained.
- **Reset mid-operation:** next cycle, all registers are at their reset values.

## Timing
- **Reset values:** state IDLE; x, y, colour 0; `x_out`, `y_out`, `colour_out` 0; `plot` 0; `finish` 0; sweep and frame counters 0.
- Outputs are registered. `draw` high at edge N puts the first pixel on the outputs after edge N+1.
- A sweep is exactly 16 consecutive `plot` cycles with no gaps.
- Step period = 16 + FRAME_DIV + 16 + 1 cycles.
- `finish` rises on the edge that leaves UPDATE. It stays high until `reset`, or until an IDLE load.

## Structure
- Package `player_pkg` holds:
  - the state enum;
  - `BG_COLOUR` = 3'b000;
  - screen-size constants;
  - a sprite pixel-count constant.
- Sub-module `sprite_sweep`:
  - has a start input, and X_W/Y_W base position inputs;
  - outputs a pixel offset (dx, dy), `busy`, and a one-cycle `done` pulse on the last pixel;
  - is shared by DRAW and ERASE.

## Test plan
- **Load and draw.** `ld_*`=1 with `x_in`=10, `y_in`=50, `colour_in`=3'b100, `draw`=0; then `draw`=`writeEnable`=1 → 16 `plot` pulses covering x 10..13, y 50..53, colour 3'b100.
- **One step** (FRAME_DIV=4). After WAIT → 16 pulses at (10..13, 50..53) with colour 000, a 1-cycle gap, then 16 pulses at (11..14, 50..53) with colour 100.
- **Clamping.** y=0 with `move_up` → next draw at y 0..3. y=116 with `move_down` → y stays 116. Both keys held → y unchanged.
- **End reached.** Start x=151 → after the first UPDATE x=152, `finish`=1, state DONE, no further `plot`.
- **Collision.** Obstacle at (20,50), player at (15,50) → collision detected at x_new=17, `finish`=1. Repeat with player at (15,42): 42..45 vs 50..57 do not overlap → no finish.
- **Aborts.** `reset` asserted at the 5th pixel of DRAW → next cycle `plot`=0, all outputs 0. `draw` dropped mid-WAIT → IDLE, position and `finish` retained.
